deserialize: RTL and testbench
==============================

Name: deserialize

Overview:
- Serial-to-parallel collector on the systolic array output side; the mirror of the input-side serializers.
- Accepts one BIT_WIDTH element per handshake from an array edge column/row and packs LENGTH elements into one parallel word.
- Presents the word through a single-entry output buffer with valid/ready, so the next word can be collected while the previous one waits.
- Element ordering is the inverse of the serializer: first element received lands in the MSB slot, so deserialize(serialize(x)) == x.

Parameters:
- LENGTH, 32, elements per parallel word (legal: ≥2).
- BIT_WIDTH, 16, bits per element.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous: discards the partial word and the output buffer.
- in_valid  input  1  serial element valid.
- in_ready  output  1  collector can accept an element this cycle.
- in  input  BIT_WIDTH  serial element.
- out_valid  output  1  out holds a complete word.
- out_ready  input  1  consumer takes out this cycle.
- out  output  LENGTH*BIT_WIDTH  parallel word; slot i is out[i*BIT_WIDTH-1 -: BIT_WIDTH], i=1..LENGTH.
- beat_count  output  clog2(LENGTH+1)  elements currently held in the collector (0..LENGTH).

Behaviour:
- Reset (rst_n low, async):
  - collector, out, beat_count = 0; out_valid = 0.
  - in_ready reads 1, but no element is accepted while rst_n is low.
  - Reset mid-word drops the partial word and any buffered word.
- Definitions:
  - accept = in_valid & in_ready.
  - in_ready = (beat_count != LENGTH), combinational.
  - buf_free = !out_valid | out_ready.
- Shift on accept: collector <= {collector[(LENGTH-1)*BIT_WIDTH-1:0], in}. The new element enters slot 1 and older elements move up one slot. After LENGTH accepts, the first element is in slot LENGTH (MSBs).
- Per cycle, in priority order:
  1. clear=1: collector <= 0, beat_count <= 0, out_valid <= 0. Any in/out handshake in that cycle is ignored, with no data effect.
  2. accept & beat_count==LENGTH-1 & buf_free: out <= shifted collector including in; out_valid <= 1; beat_count <= 0. Zero-bubble path.
  3. accept & beat_count==LENGTH-1 & !buf_free: collector shifts; beat_count <= LENGTH. in_ready drops next cycle (stall).
  4. beat_count==LENGTH & buf_free: out <= collector, out_valid <= 1, beat_count <= 0. in_ready returns to 1 the following cycle.
  5. Otherwise, accept: shift, beat_count++.
  6. In any case with no load into out: out_valid & out_ready clears out_valid.
- Latency:
  - Zero-bubble path: out_valid rises on the edge that accepts the LENGTH-th element.
  - Stalled path: out_valid rises one edge after the buffer frees.
- Throughput: one element per cycle sustained while the consumer holds out_ready=1. No bubble between words.
- out is stable while out_valid=1 and out_ready=0. out keeps its last value after being consumed; it is not zeroed.
- A simultaneous consume and load in the same cycle is a load: out_valid stays 1 and out takes the new word.
- beat_count wraps LENGTH-1 → 0 (or → LENGTH → 0); it never exceeds LENGTH.
- in is ignored when in_valid=0 or in_ready=0.

Test Plan:
- LENGTH=4, BW=16, out_ready=1; send 0x0001,0x0002,0x0003,0x0004 back-to-back → out_valid high after the 4th accept edge; out=0x0001_0002_0003_0004; in_ready never drops.
- Same config; 8 back-to-back elements 1..8 with out_ready=1 → two words, 0x0001_0002_0003_0004 then 0x0005_0006_0007_0008, on consecutive word boundaries with no idle cycle.
- out_ready=0; send 1..8 → first word held stable; beat_count reaches 4 and in_ready=0; element 9 offered is not accepted. Raise out_ready for 1 cycle → word 1 consumed; next edge word 2 loads into out; in_ready=1 again.
- Send 3 elements, assert clear one cycle, then send 0xA,0xB,0xC,0xD → out=0x000A_000B_000C_000D; earlier elements absent.
- Send 2 elements, pulse rst_n low asynchronously between edges → beat_count=0 and out_valid=0 immediately; a subsequent 4-element word is correct.
- Defaults (32×16): round-trip 32 random elements through a serialize instance into this block → out equals the serializer's loaded word bit-for-bit.

Source files
------------

// File: rtl/deserialize_if.sv
// deserialize_if: bundles the serial input stream, the parallel output stream
// and the collector status of the deserializer.
//   clear       synchronous discard of the partial word and the output buffer
//   in_valid / in_ready / in     serial element handshake (BIT_WIDTH bits)
//   out_valid / out_ready / out  parallel word handshake (LENGTH*BIT_WIDTH bits)
//   beat_count  elements currently held in the collector (0..LENGTH)
// master = the side driving elements and consuming words; slave = the deserializer.
interface deserialize_if #(
    parameter int LENGTH    = 32,
    parameter int BIT_WIDTH = 16
);
    localparam int CW = $clog2(LENGTH + 1);

    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic [BIT_WIDTH-1:0]        in;
    logic                        out_valid;
    logic                        out_ready;
    logic [LENGTH*BIT_WIDTH-1:0] out;
    logic [CW-1:0]               beat_count;

    modport master (
        output clear, in_valid, in, out_ready,
        input  in_ready, out_valid, out, beat_count
    );

    modport slave (
        input  clear, in_valid, in, out_ready,
        output in_ready, out_valid, out, beat_count
    );
endinterface

// File: rtl/deserialize.sv
// deserialize: serial-to-parallel collector for the systolic array output side.
// Packs LENGTH elements of BIT_WIDTH bits into one word; the first element
// received ends up in the MSB slot, so this undoes the input-side serializer.
// A single-entry output buffer lets the next word be collected while the
// previous one waits for the consumer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   s      deserialize_if.slave (clear, in handshake, out handshake, beat_count)
module deserialize #(
    parameter int LENGTH    = 32,
    parameter int BIT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    deserialize_if.slave s
);
    localparam int W  = LENGTH * BIT_WIDTH;
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] FULL = CW'(LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    logic [W-1:0]  collector;
    logic [W-1:0]  shifted;
    logic [W-1:0]  out_q;
    logic          out_valid_q;
    logic [CW-1:0] beat_q;
    logic          accept;
    logic          buf_free;

    assign s.in_ready   = (beat_q != FULL);
    assign s.out_valid  = out_valid_q;
    assign s.out        = out_q;
    assign s.beat_count = beat_q;

    assign accept   = s.in_valid & s.in_ready;
    assign buf_free = ~out_valid_q | s.out_ready;

    // New element enters slot 1; older ones move toward the MSBs.
    assign shifted = {collector[W-BIT_WIDTH-1:0], s.in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collector   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (s.clear) begin
            // out keeps its old contents; only the valid flag is dropped.
            collector   <= '0;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (accept && beat_q == LAST) begin
            collector <= shifted;
            if (buf_free) begin
                // Zero-bubble: last element goes straight into the buffer.
                out_q       <= shifted;
                out_valid_q <= 1'b1;
                beat_q      <= '0;
            end else begin
                // Buffer still occupied: park the full word, stall input.
                beat_q <= FULL;
            end
        end else if (beat_q == FULL && buf_free) begin
            out_q       <= collector;
            out_valid_q <= 1'b1;
            beat_q      <= '0;
        end else begin
            if (accept) begin
                collector <= shifted;
                beat_q    <= beat_q + CW'(1);
            end
            if (out_valid_q && s.out_ready)
                out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_deserialize.sv
// Bench for deserialize: a 4x16 instance checked every cycle against a
// queue-based model (elements collect in a queue; a full queue moves into the
// one-word buffer when it is free), directed literal scenarios, random traffic
// and a 32x16 round trip through a behavioural serializer.
module tb_deserialize;
    localparam int L  = 4;
    localparam int BW = 16;
    localparam int BL = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deserialize_if #(.LENGTH(L),  .BIT_WIDTH(BW)) s_if ();
    deserialize_if #(.LENGTH(BL), .BIT_WIDTH(BW)) b_if ();

    deserialize #(.LENGTH(L), .BIT_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .s(s_if.slave)
    );
    deserialize #(.LENGTH(BL), .BIT_WIDTH(BW)) dut_big (
        .clk(clk), .rst_n(rst_n), .s(b_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 4x16 instance ----------------
    logic [BW-1:0]  mq[$];
    logic           mv = 1'b0;
    logic [L*BW-1:0] mw = '0;

    function automatic logic [L*BW-1:0] pack4(input logic [BW-1:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mv = 1'b0;
            mw = '0;
        end else if (s_if.clear) begin
            mq.delete();
            mv = 1'b0;
        end else begin
            bit free, rdy;
            free = !mv || s_if.out_ready;
            rdy  = (mq.size() != L);
            if (s_if.in_valid && rdy) mq.push_back(s_if.in);
            if (mq.size() == L && free) begin
                mw = pack4(mq[0], mq[1], mq[2], mq[3]);
                mv = 1'b1;
                mq.delete();
            end else if (mv && s_if.out_ready) begin
                mv = 1'b0;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",   512'(s_if.in_ready),   512'(mq.size() != L));
        chk("out_valid",  512'(s_if.out_valid),  512'(mv));
        chk("beat_count", 512'(s_if.beat_count), 512'(mq.size()));
        chk("out",        512'(s_if.out),        512'(mw));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] d);
        s_if.in_valid = 1'b1;
        s_if.in       = d;
        step();
        s_if.in_valid = 1'b0;
    endtask

    logic [BL*BW-1:0] x;

    initial begin
        s_if.clear = 0; s_if.in_valid = 0; s_if.in = '0; s_if.out_ready = 1;
        b_if.clear = 0; b_if.in_valid = 0; b_if.in = '0; b_if.out_ready = 1;
        #1;
        chk("reset out_valid", 512'(s_if.out_valid), 512'(0));
        chk("reset in_ready",  512'(s_if.in_ready),  512'(1));
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Back-to-back single word, consumer always ready.
        for (int e = 1; e <= 4; e++) begin
            send(BW'(e));
            chk("t1 in_ready", 512'(s_if.in_ready), 512'(1));
        end
        chk("t1 out_valid", 512'(s_if.out_valid), 512'(1));
        chk("t1 out", 512'(s_if.out), 512'(64'h0001_0002_0003_0004));
        step();
        chk("t1 consumed", 512'(s_if.out_valid), 512'(0));

        // Two words with no idle cycle between them.
        s_if.in_valid = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            s_if.in = BW'(e);
            step();
            chk("t2 in_ready", 512'(s_if.in_ready), 512'(1));
            if (e == 4) chk("t2 word1", 512'(s_if.out), 512'(64'h0001_0002_0003_0004));
            if (e == 8) chk("t2 word2", 512'(s_if.out), 512'(64'h0005_0006_0007_0008));
            if (e == 4 || e == 8) chk("t2 valid", 512'(s_if.out_valid), 512'(1));
        end
        s_if.in_valid = 1'b0;
        step();

        // Stall: consumer not ready.
        s_if.out_ready = 1'b0;
        for (int e = 1; e <= 8; e++) send(BW'(e));
        chk("t3 beat_count", 512'(s_if.beat_count), 512'(4));
        chk("t3 in_ready",   512'(s_if.in_ready),   512'(0));
        chk("t3 held",       512'(s_if.out),        512'(64'h0001_0002_0003_0004));
        send(16'h0009);
        chk("t3 not taken",  512'(s_if.beat_count), 512'(4));
        chk("t3 stable",     512'(s_if.out),        512'(64'h0001_0002_0003_0004));
        s_if.out_ready = 1'b1;
        step();
        s_if.out_ready = 1'b0;
        chk("t3 word2",      512'(s_if.out),        512'(64'h0005_0006_0007_0008));
        chk("t3 valid",      512'(s_if.out_valid),  512'(1));
        chk("t3 ready back", 512'(s_if.in_ready),   512'(1));
        s_if.out_ready = 1'b1;
        step();

        // Clear drops a partial word.
        for (int e = 1; e <= 3; e++) send(BW'(e + 16'h20));
        s_if.clear = 1'b1;
        step();
        s_if.clear = 1'b0;
        chk("t4 cleared", 512'(s_if.beat_count), 512'(0));
        send(16'h000A); send(16'h000B); send(16'h000C); send(16'h000D);
        chk("t4 out", 512'(s_if.out), 512'(64'h000A_000B_000C_000D));

        // Asynchronous reset with a buffered word and a partial word.
        s_if.out_ready = 1'b0;
        for (int e = 1; e <= 6; e++) send(BW'(e + 16'h40));
        #3 rst_n = 1'b0;
        #1;
        chk("t5 beat_count", 512'(s_if.beat_count), 512'(0));
        chk("t5 out_valid",  512'(s_if.out_valid),  512'(0));
        chk("t5 out",        512'(s_if.out),        512'(0));
        #1 rst_n = 1'b1;
        s_if.out_ready = 1'b1;
        step();
        for (int e = 1; e <= 4; e++) send(BW'(e + 16'h10));
        chk("t5 word", 512'(s_if.out), 512'(64'h0011_0012_0013_0014));
        chk("t5 valid", 512'(s_if.out_valid), 512'(1));

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            s_if.in_valid  = ($urandom_range(0, 3) != 0);
            s_if.in        = BW'($urandom);
            s_if.out_ready = ($urandom_range(0, 2) != 0);
            s_if.clear     = ($urandom_range(0, 39) == 0);
            step();
        end
        s_if.in_valid = 0; s_if.clear = 0; s_if.out_ready = 1;
        step();

        // 32x16 round trip through a behavioural serializer (MSB slot first).
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < BL; i++) x[i*BW +: BW] = BW'($urandom);
            b_if.in_valid = 1'b1;
            for (int i = BL; i >= 1; i--) begin
                b_if.in = x[i*BW-1 -: BW];
                step();
                if (i == BL / 2) chk("rt beat_count", 512'(b_if.beat_count), 512'(BL / 2 + 1));
            end
            b_if.in_valid = 1'b0;
            chk("rt out_valid", 512'(b_if.out_valid), 512'(1));
            chk("rt out", 512'(b_if.out), 512'(x));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
